mips_bus_memory: RTL and testbench

// - Avalon-style memory slave consumed by mips_cpu_bus; replaces ad-hoc bench RAM for CPU tests.
// - Two byte-addressed regions: data RAM at 0x0000_0000 and instruction memory at reset vector INSTR_BASE.
// - Inserts programmable wait states via waitrequest; byte-lane writes via byteenable.
// - Flags misaligned or unmapped accesses.

---
 rtl/mips_bus_memory.sv | 147 ++++++++++++++
 tb/tb_mips_bus_memory.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_memory.sv
// mips_bus_memory: Avalon-style slave, data RAM at 0 plus instruction memory at INSTR_BASE.
// Ports: clk, reset_n, address, read, write, byteenable, writedata -> readdata, waitrequest, err.
// Option: define MIPS_BUS_MEMORY_RANDOM_WAIT_EN for LFSR-chosen wait counts per access.
module mips_bus_memory #(
  parameter int unsigned DATA_BYTES  = 1024,
  parameter int unsigned INSTR_BYTES = 1024,
  parameter logic [31:0] INSTR_BASE  = 32'hBFC00000,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter string       DATA_INIT   = "",
  parameter string       INSTR_INIT  = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        err
);

  localparam int unsigned DWORDS = DATA_BYTES / 4;
  localparam int unsigned IWORDS = INSTR_BYTES / 4;
  localparam int unsigned DAW = (DWORDS > 1) ? $clog2(DWORDS) : 1;
  localparam int unsigned IAW = (IWORDS > 1) ? $clog2(IWORDS) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t         state, state_nx;
  logic [3:0]     cnt, cnt_nx;
  logic [3:0]     wait_n;
  logic [31:0]    dmem [DWORDS];
  logic [31:0]    imem [IWORDS];
  logic [31:0]    ioff;
  logic [DAW-1:0] didx;
  logic [IAW-1:0] iidx;
  logic           in_d, in_i, bad, req;
  logic           done, wr_c, wr_en;
  logic [31:0]    lane, word, rd_c, rd_q;
  logic           err_q;

  initial begin
    dmem = '{default: '0};
    imem = '{default: '0};
  end

  // Unsigned wrap makes the single compare cover both bounds.
  assign ioff = address - INSTR_BASE;
  assign in_d = address < 32'(DATA_BYTES);
  assign in_i = ioff < 32'(INSTR_BYTES);
  assign didx = address[DAW+1:2];
  assign iidx = ioff[IAW+1:2];
  assign req  = read | write;
  assign bad  = (|address[1:0]) | ~(in_d | in_i)
              | (read & write);

  assign lane = {{8{byteenable[3]}}, {8{byteenable[2]}},
                 {8{byteenable[1]}}, {8{byteenable[0]}}};
  assign word = in_d ? dmem[didx] : imem[iidx];
  assign rd_c = bad ? 32'h0 : (word & lane);

`ifdef MIPS_BUS_MEMORY_RANDOM_WAIT_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= 16'hACE1;
    end else if (done) begin
      lfsr <= {1'b0, lfsr[15:1]}
            ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign wait_n = 4'({1'b0, lfsr[3:0]}
                  % 5'(WAIT_CYCLES + 1));
`else
  assign wait_n = 4'(WAIT_CYCLES);
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wr_c     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (wait_n == 4'd0) begin
            done = 1'b1;
          end else begin
            wr_c     = 1'b1;
            cnt_nx   = wait_n - 4'd1;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nx = IDLE;
        end else if (cnt != 4'd0) begin
          wr_c   = 1'b1;
          cnt_nx = cnt - 4'd1;
        end else begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Gating by reset_n drops the stall and any completion
  // the instant reset is asserted.
  assign waitrequest = wr_c & reset_n;
  assign readdata    = (done & read & reset_n) ? rd_c : rd_q;
  assign err         = err_q;
  assign wr_en       = done & write & ~bad & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rd_q  <= 32'h0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (done && read) rd_q <= rd_c;
      if (done && bad) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (in_d) begin
        dmem[didx] <= (dmem[didx] & ~lane)
                    | (writedata & lane);
      end else begin
        imem[iidx] <= (imem[iidx] & ~lane)
                    | (writedata & lane);
      end
    end
  end

endmodule

// File: tb/tb_mips_bus_memory.sv
// tb_mips_bus_memory: random accesses against a byte-array model.
// Second instance runs with zero wait states.
module tb_mips_bus_memory;

  localparam int          WC    = 2;
  localparam int unsigned DB    = 1024;
  localparam int unsigned IB    = 1024;
  localparam logic [31:0] IBASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest, err;
  logic [3:0]  byteenable;
  logic [31:0] address0, writedata0, readdata0;
  logic        read0, write0, waitrequest0, err0;
  logic [3:0]  byteenable0;

  always #5 clk = ~clk;

  mips_bus_memory #(.WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset_n(reset_n), .address(address),
    .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest), .err(err)
  );

  mips_bus_memory #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address0),
    .read(read0), .write(write0), .byteenable(byteenable0),
    .writedata(writedata0), .readdata(readdata0),
    .waitrequest(waitrequest0), .err(err0)
  );

  byte unsigned mdat [DB];
  byte unsigned mins [IB];
  bit           exp_err;
  logic [15:0]  m_lfsr;
  int           checks, failures;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_bad(logic [31:0] a, bit r, bit w);
    bit mapped;
    mapped = (a < DB) || (a >= IBASE && a < IBASE + IB);
    return (a[1:0] != 2'b00) || !mapped || (r && w);
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a,
                                         logic [3:0] be);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        if (a < DB) v[8*i +: 8] = mdat[10'(a) + 10'(i)];
        else        v[8*i +: 8] = mins[10'(a - IBASE) + 10'(i)];
      end
    end
    return v;
  endfunction

  task automatic m_write(input logic [31:0] a,
                         input logic [3:0] be,
                         input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        if (a < DB) mdat[10'(a) + 10'(i)] = d[8*i +: 8];
        else        mins[10'(a - IBASE) + 10'(i)] = d[8*i +: 8];
      end
    end
  endtask

  function automatic int exp_wait();
`ifdef MIPS_BUS_MEMORY_RANDOM_WAIT_EN
    return int'(m_lfsr[3:0]) % (WC + 1);
`else
    return WC;
`endif
  endfunction

  task automatic m_step();
    if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
    else           m_lfsr = m_lfsr >> 1;
  endtask

  task automatic m_reset();
    exp_err = 1'b0;
    m_lfsr  = 16'hACE1;
  endtask

  // Called 1 time unit after a rising edge; returns the same way.
  task automatic access(input bit r, input bit w,
                        input logic [31:0] a,
                        input logic [3:0] be,
                        input logic [31:0] wd,
                        input string tag,
                        output logic [31:0] rd);
    int          stalls, ew;
    bit          b;
    logic [31:0] erd;
    ew  = exp_wait();
    b   = m_bad(a, r, w);
    erd = (r && !b) ? m_read(a, be) : 32'h0;
    address = a; read = r; write = w;
    byteenable = be; writedata = wd;
    stalls = 0;
    @(negedge clk);
    while (waitrequest === 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    rd = readdata;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    check({tag, "_stalls"}, 32'(stalls), 32'(ew));
    if (r) check({tag, "_rdata"}, rd, erd);
    if (w && !b) m_write(a, be, wd);
    if (b) exp_err = 1'b1;
    m_step();
    check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic [3:0]  be;
    bit          r;
    int          ew;
    checks = 0; failures = 0;
    m_reset();
    for (int i = 0; i < int'(DB); i++) mdat[i] = 8'h00;
    for (int i = 0; i < int'(IB); i++) mins[i] = 8'h00;
    reset_n = 1'b0;
    address = 0; read = 0; write = 0;
    byteenable = 0; writedata = 0;
    address0 = 0; read0 = 0; write0 = 0;
    byteenable0 = 0; writedata0 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wait", {31'b0, waitrequest}, 32'h0);
    check("rst_rdata", readdata, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    access(0, 1, IBASE, 4'hF, 32'h24020005, "iwr", rd);
    access(1, 0, IBASE, 4'hF, 32'h0, "ird", rd);
    check("ird_val", rd, 32'h24020005);

    access(0, 1, 32'h10, 4'b0101, 32'hDEADBEEF, "lanewr", rd);
    access(1, 0, 32'h10, 4'hF, 32'h0, "lanerd", rd);
    check("lane_val", rd, 32'h00AD00EF);

    access(0, 1, DB - 4, 4'hF, 32'h11223344, "topwr", rd);
    access(1, 0, DB - 4, 4'b1001, 32'h0, "toprd", rd);
    access(0, 1, 32'h18, 4'b0000, 32'hFFFFFFFF, "be0wr", rd);
    access(1, 0, 32'h18, 4'hF, 32'h0, "be0rd", rd);

    for (int n = 0; n < 80; n++) begin
      if (($urandom % 4) == 0) a = 32'($urandom_range(0, DB / 4 - 1)) * 4;
      else a = 32'($urandom_range(0, 15)) * 4;
      if ($urandom % 2 == 1) a = a + IBASE;
      be = 4'($urandom);
      wd = $urandom;
      r  = ($urandom % 2) == 1;
      access(r, !r, a, be, wd, "rnd", rd);
      if (r && (n % 4 == 0)) begin
        @(negedge clk);
        check("hold", readdata, rd);
        @(posedge clk); #1;
      end
    end

    address0 = 32'h40; byteenable0 = 4'hF; read0 = 1'b1;
    @(negedge clk);
    check("w0_rd_wait", {31'b0, waitrequest0}, 32'h0);
    check("w0_rd_val", readdata0, 32'h0);
    @(posedge clk); #1;
    read0 = 1'b0; write0 = 1'b1; writedata0 = 32'hCAFEF00D;
    @(negedge clk);
    check("w0_wr_wait", {31'b0, waitrequest0}, 32'h0);
    @(posedge clk); #1;
    write0 = 1'b0; read0 = 1'b1;
    @(negedge clk);
    check("w0_rd2_wait", {31'b0, waitrequest0}, 32'h0);
    check("w0_rd2_val", readdata0, 32'hCAFEF00D);
    @(posedge clk); #1;
    read0 = 1'b0;

    ew = exp_wait();
    if (ew > 0) begin
      address = 32'h24; byteenable = 4'hF;
      writedata = 32'hA5A5A5A5; write = 1'b1;
      @(negedge clk);
      check("abort_wait", {31'b0, waitrequest}, 32'h1);
      @(posedge clk); #1;
      write = 1'b0;
      @(negedge clk);
      check("abort_idle", {31'b0, waitrequest}, 32'h0);
      @(posedge clk); #1;
    end
    access(1, 0, 32'h24, 4'hF, 32'h0, "abort_rd", rd);

    access(1, 0, DB, 4'hF, 32'h0, "unmap", rd);
    access(1, 0, 32'h2, 4'hF, 32'h0, "misal", rd);
    check("misal_val", rd, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("err_hold", {31'b0, err}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("err_clr", {31'b0, err}, 32'h0);
    check("rdata_clr", readdata, 32'h0);
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 2; k++) begin
      ew = exp_wait();
      if (ew > 0) begin
        address = (k == 0) ? 32'h12345678 : 32'h30;
        byteenable = 4'hF;
        writedata = 32'hFFFFFFFF; write = 1'b1;
        @(negedge clk);
        check("mid_wait", {31'b0, waitrequest}, 32'h1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("mid_wdrop", {31'b0, waitrequest}, 32'h0);
        check("mid_err", {31'b0, err}, 32'h0);
        write = 1'b0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
      end
    end
    access(1, 0, 32'h30, 4'hF, 32'h0, "post_rst", rd);
    access(1, 0, 32'h10, 4'hF, 32'h0, "final_d", rd);
    access(1, 0, IBASE, 4'hF, 32'h0, "final_i", rd);
    check("w0_err", {31'b0, err0}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
